uart_tx: RTL and testbench

- Transmit-side consumer of the UART FIFO.
- Pops bytes from the FIFO read side and serializes them onto the tx line as UART frames: start bit, data bits LSB-first, optional parity, 1 or 2 stop bits.
- Owns its own bit-period counter.
- Sits between the FIFO read port and the pad.

---
 rtl/uart_pkg.sv | 34 +++
 rtl/uart_tx_if.sv | 30 +++
 rtl/uart_bit_timer.sv | 38 +++
 rtl/uart_tx.sv | 163 ++++++++++++++++
 tb/tb_uart_tx.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared UART definitions: transmitter state encoding,
//                parity-mode constants and a frame-length helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // Transmitter frame phases
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_t;

    // Value XORed onto the data reduction to form the parity bit
    localparam logic PARITY_MODE_EVEN = 1'b0;
    localparam logic PARITY_MODE_ODD  = 1'b1;

    // Cycles from the start-bit falling edge to the end of the last stop bit
    function automatic int unsigned frame_cycles(
        input int unsigned data_width,
        input int unsigned clks_per_bit,
        input int unsigned parity_en,
        input int unsigned stop_bits
    );
        return (1 + data_width + parity_en + stop_bits) * clks_per_bit;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_if.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_if
//  Description : Show-ahead FIFO read port between the UART FIFO and the
//                transmitter. master = consumer (transmitter),
//                slave = FIFO read side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface uart_tx_if #(
    parameter int DATA_WIDTH = 8
) ();

    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_rd_data;
    logic                  fifo_rd_en;

    modport master (
        input  fifo_empty,
        input  fifo_rd_data,
        output fifo_rd_en
    );

    modport slave (
        output fifo_empty,
        output fifo_rd_data,
        input  fifo_rd_en
    );

endinterface
`default_nettype wire

// File: rtl/uart_bit_timer.sv
`default_nettype none
// ============================================================================
//  Module      : uart_bit_timer
//  Description : Bit-period counter running 0..CLKS_PER_BIT-1. bit_end is
//                high in the last cycle of each bit period; clear restarts
//                the period at count 0 on the next edge. Shared by the
//                transmitter and receiver. rst is asynchronous, active-low.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_bit_timer #(
    parameter int CLKS_PER_BIT = 16
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic clear,
    output logic      bit_end
);

    localparam int               CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] count;

    assign bit_end = (count == LAST);

    // Count through one bit period, wrapping at the end or on clear
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clear || bit_end) begin
            count <= '0;
        end else begin
            count <= count + CNT_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx
//  Description : UART transmitter. Pops words from a show-ahead FIFO and
//                serialises them as start bit, LSB-first data, optional
//                parity and 1 or 2 stop bits. Back-to-back words follow
//                with no idle gap. rst is asynchronous, active-low.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int STOP_BITS    = 1,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0
) (
    input  wire logic clk,
    input  wire logic rst,
    uart_tx_if.master fifo,
    output logic      tx,
    output logic      tx_busy,
    output logic      tx_done
);

    localparam int   IDX_W       = $clog2(DATA_WIDTH);
    localparam logic PARITY_ON   = (PARITY_EN != 0);
    localparam logic PARITY_MODE = (PARITY_ODD != 0) ? PARITY_MODE_ODD
                                                     : PARITY_MODE_EVEN;
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DATA_WIDTH - 1);
    localparam logic             LAST_STOP = 1'(STOP_BITS - 1);

    uart_state_t           state;
    uart_state_t           state_next;
    logic [DATA_WIDTH-1:0] shift;
    logic                  parity_bit;
    logic [IDX_W-1:0]      bit_idx;
    logic                  stop_idx;
    logic                  bit_end;
    logic                  last_data;
    logic                  last_stop;
    logic                  pop;
    logic                  timer_clear;

    // ------------------------------------------------------------------
    // Bit-period timer: held at zero while idle and restarted on a pop so
    // every frame starts on a fresh bit boundary.
    // ------------------------------------------------------------------
    assign timer_clear = (state == ST_IDLE) || pop;

    uart_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_bit_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (timer_clear),
        .bit_end (bit_end)
    );

    // ------------------------------------------------------------------
    // Frame boundary decodes and the pop strobe. The pop is gated with
    // reset so no word is consumed while the block is held in reset.
    // ------------------------------------------------------------------
    assign last_data = (state == ST_DATA) && bit_end && (bit_idx == LAST_IDX);
    assign last_stop = (state == ST_STOP) && bit_end && (stop_idx == LAST_STOP);
    assign pop       = rst && !fifo.fifo_empty &&
                       ((state == ST_IDLE) || last_stop);

    assign fifo.fifo_rd_en = pop;
    assign tx_done         = last_stop;
    assign tx_busy         = (state != ST_IDLE);

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode; a pop in the final stop cycle chains straight
    // into the next start bit
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (pop) begin
                    state_next = ST_START;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    state_next = ST_DATA;
                end
            end
            ST_DATA: begin
                if (last_data) begin
                    state_next = PARITY_ON ? ST_PARITY : ST_STOP;
                end
            end
            ST_PARITY: begin
                if (bit_end) begin
                    state_next = ST_STOP;
                end
            end
            ST_STOP: begin
                if (last_stop) begin
                    state_next = pop ? ST_START : ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Datapath: latch word and parity on a pop, then at each bit end load
    // the tx register with the level of the bit that follows
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx         <= 1'b1;
            shift      <= '0;
            parity_bit <= 1'b0;
            bit_idx    <= '0;
            stop_idx   <= 1'b0;
        end else if (pop) begin
            shift      <= fifo.fifo_rd_data;
            parity_bit <= (^fifo.fifo_rd_data) ^ PARITY_MODE;
            tx         <= 1'b0;
            bit_idx    <= '0;
            stop_idx   <= 1'b0;
        end else if (bit_end) begin
            case (state)
                ST_START: begin
                    tx <= shift[0];
                end
                ST_DATA: begin
                    shift <= shift >> 1;
                    if (bit_idx == LAST_IDX) begin
                        tx <= PARITY_ON ? parity_bit : 1'b1;
                    end else begin
                        tx      <= shift[1];
                        bit_idx <= bit_idx + IDX_W'(1);
                    end
                end
                ST_PARITY: begin
                    tx <= 1'b1;
                end
                ST_STOP: begin
                    tx       <= 1'b1;
                    stop_idx <= stop_idx + 1'b1;
                end
                default: begin
                    tx <= 1'b1;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_tx
//  Description : Self-checking bench for uart_tx. Four instances at
//                CLKS_PER_BIT=4: plain 8N1, even parity, odd parity and two
//                stop bits, each fed by a small show-ahead FIFO model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx;
    import uart_pkg::*;

    localparam int CPB  = 4;
    localparam int NDUT = 4;

    typedef struct {
        int         sel;
        logic [7:0] data;
        logic [11:0] bits;   // expected line levels per bit, bit 0 first
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] mem    [NDUT][8];
    logic [7:0] wr_ptr [NDUT];

    logic [NDUT-1:0] tx_v;
    logic [NDUT-1:0] busy_v;
    logic [NDUT-1:0] done_v;
    logic [NDUT-1:0] rden_v;

    int n_checks = 0;
    int n_fail   = 0;

    vec_t vecs [10];

    // One DUT plus its FIFO read-side model per configuration
    generate
        for (genvar i = 0; i < NDUT; i++) begin : g_dut
            logic [7:0] rd_ptr = 8'd0;
            uart_tx_if #(.DATA_WIDTH(8)) ifc ();

            assign ifc.fifo_empty   = (wr_ptr[i] == rd_ptr);
            assign ifc.fifo_rd_data = mem[i][rd_ptr[2:0]];
            assign rden_v[i]        = ifc.fifo_rd_en;

            always @(posedge clk) begin
                if (ifc.fifo_rd_en) rd_ptr <= rd_ptr + 8'd1;
            end

            uart_tx #(
                .DATA_WIDTH   (8),
                .CLKS_PER_BIT (CPB),
                .STOP_BITS    ((i == 3) ? 2 : 1),
                .PARITY_EN    ((i == 1 || i == 2) ? 1 : 0),
                .PARITY_ODD   ((i == 2) ? 1 : 0)
            ) dut (
                .clk     (clk),
                .rst     (rst),
                .fifo    (ifc),
                .tx      (tx_v[i]),
                .tx_busy (busy_v[i]),
                .tx_done (done_v[i])
            );
        end
    endgenerate

    function automatic int unsigned pe_of(input int s);
        return (s == 1 || s == 2) ? 1 : 0;
    endfunction

    function automatic int unsigned sb_of(input int s);
        return (s == 3) ? 2 : 1;
    endfunction

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push(input int s, input logic [7:0] d);
        mem[s][wr_ptr[s][2:0]] = d;
        wr_ptr[s] = wr_ptr[s] + 8'd1;
    endtask

    // Called right after a push on a falling edge; follows nframes frames
    // cycle by cycle and then checks the return to idle
    task automatic run_seq(input int s, input int nframes, input logic [23:0] bits);
        int   flen;
        int   total;
        logic last;
        flen  = int'(frame_cycles(8, CPB, pe_of(s), sb_of(s)));
        total = flen * nframes;
        #1;
        check_bit($sformatf("rd_en at pop v%0d", s), rden_v[s], 1'b1);
        for (int c = 1; c <= total; c++) begin
            @(negedge clk);
            last = ((c % flen) == 0);
            check_bit($sformatf("tx v%0d c%0d", s, c), tx_v[s], bits[(c-1)/CPB]);
            check_bit($sformatf("busy v%0d c%0d", s, c), busy_v[s], 1'b1);
            check_bit($sformatf("done v%0d c%0d", s, c), done_v[s], last);
            check_bit($sformatf("rd_en v%0d c%0d", s, c), rden_v[s], last && (c != total));
        end
        @(negedge clk);
        check_bit($sformatf("idle tx v%0d", s), tx_v[s], 1'b1);
        check_bit($sformatf("idle busy v%0d", s), busy_v[s], 1'b0);
        check_bit($sformatf("idle done v%0d", s), done_v[s], 1'b0);
    endtask

    // Count cycles where any instance leaves the idle output pattern
    task automatic idle_check(input int ncyc, input string tag);
        int bad [NDUT];
        for (int s = 0; s < NDUT; s++) bad[s] = 0;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            for (int s = 0; s < NDUT; s++) begin
                if (tx_v[s] !== 1'b1 || busy_v[s] !== 1'b0 ||
                    rden_v[s] !== 1'b0 || done_v[s] !== 1'b0) bad[s]++;
            end
        end
        for (int s = 0; s < NDUT; s++) begin
            check_int($sformatf("%s non-idle cycles v%0d", tag, s), bad[s], 0);
        end
    endtask

    initial begin
        // sel, data, line levels written last-bit-first (bit 0 = start bit)
        vecs[0] = '{0, 8'hA5, 12'b00_1101001010};
        vecs[1] = '{0, 8'h00, 12'b00_1000000000};
        vecs[2] = '{0, 8'hFF, 12'b00_1111111110};
        vecs[3] = '{1, 8'hA5, 12'b0_10101001010};
        vecs[4] = '{2, 8'hA5, 12'b0_11101001010};
        vecs[5] = '{1, 8'h01, 12'b0_11000000010};
        vecs[6] = '{2, 8'h01, 12'b0_10000000010};
        vecs[7] = '{3, 8'hFF, 12'b0_11111111110};
        vecs[8] = '{3, 8'h3C, 12'b0_11001111000};
        vecs[9] = '{0, 8'h3C, 12'b00_1001111000};

        for (int s = 0; s < NDUT; s++) begin
            wr_ptr[s] = 8'd0;
            for (int k = 0; k < 8; k++) mem[s][k] = 8'h00;
        end

        // Reset state
        rst = 1'b0;
        @(negedge clk);
        for (int s = 0; s < NDUT; s++) begin
            check_bit($sformatf("reset tx v%0d", s), tx_v[s], 1'b1);
            check_bit($sformatf("reset busy v%0d", s), busy_v[s], 1'b0);
            check_bit($sformatf("reset done v%0d", s), done_v[s], 1'b0);
            check_bit($sformatf("reset rd_en v%0d", s), rden_v[s], 1'b0);
        end
        @(negedge clk);
        rst = 1'b1;

        // Empty FIFO: nothing happens for 200 cycles
        idle_check(200, "empty");

        // Single-frame vectors across all configurations
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            push(vecs[k].sel, vecs[k].data);
            run_seq(vecs[k].sel, 1, {12'h000, vecs[k].bits});
        end

        // Back-to-back 0x55 then 0x0F: no gap, second pop at cycle 40
        @(negedge clk);
        push(0, 8'h55);
        push(0, 8'h0F);
        run_seq(0, 2, {4'h0, 20'b1000011110_1010101010});

        // Reset in cycle 15 of an 0xA5 frame
        @(negedge clk);
        push(0, 8'hA5);
        #1;
        check_bit("mid rd_en at pop", rden_v[0], 1'b1);
        repeat (15) @(negedge clk);
        check_bit("mid busy before reset", busy_v[0], 1'b1);
        rst = 1'b0;
        #1;
        check_bit("mid async tx", tx_v[0], 1'b1);
        check_bit("mid async busy", busy_v[0], 1'b0);
        check_bit("mid async rd_en", rden_v[0], 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        idle_check(20, "post-reset");

        // Clean frame after reset
        @(negedge clk);
        push(0, 8'h3C);
        run_seq(0, 1, {14'h0000, 10'b1001111000});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
